// File: rtl/ctrl_pkg.sv
// Shared opcode constants, ALU/forwarding encodings and the per-stage control
// bundle types for the integer-core control pipeline.
package ctrl_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic reg_wr;
        logic mem_to_reg;
    } wb_ctrl_t;

    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic [2:0] rw_type;
    } mem_ctrl_t;

    typedef struct packed {
        logic    alu_src1;
        logic    alu_src2;
        alu_op_e alu_op;
    } ex_ctrl_t;

    typedef struct packed {
        logic      valid;
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ctrl_t;

    function automatic alu_op_e alu_from_funct(input logic f7_5, input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            3'b000:  op = f7_5 ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID-stage decoder: instruction fields to control bundle,
// register-use flags and illegal-opcode flag.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic              funct7_5_i,
    input  logic [REG_AW-1:0] rd_i,
    output ctrl_t             ctrl_o,
    output logic              uses_rs1_o,
    output logic              uses_rs2_o,
    output logic              illegal_o
);

    always_comb begin
        ctrl_o     = '0;
        uses_rs1_o = 1'b0;
        uses_rs2_o = 1'b0;
        illegal_o  = 1'b0;
        ctrl_o.valid = 1'b1;
        case (opcode_i)
            OP_R: begin
                uses_rs1_o = 1'b1;
                uses_rs2_o = 1'b1;
                ctrl_o.wb.reg_wr = 1'b1;
                ctrl_o.ex.alu_op = alu_from_funct(funct7_5_i, funct3_i);
            end
            OP_I: begin
                uses_rs1_o = 1'b1;
                ctrl_o.ex.alu_src2 = 1'b1;
                ctrl_o.wb.reg_wr = 1'b1;
                // funct7 bit 5 is an immediate bit except for the shift-right pair
                ctrl_o.ex.alu_op = alu_from_funct((funct3_i == 3'b101) && funct7_5_i, funct3_i);
            end
            OP_LOAD: begin
                uses_rs1_o = 1'b1;
                ctrl_o.ex.alu_src2 = 1'b1;
                ctrl_o.mem.mem_rd = 1'b1;
                ctrl_o.mem.rw_type = funct3_i;
                ctrl_o.wb.reg_wr = 1'b1;
                ctrl_o.wb.mem_to_reg = 1'b1;
            end
            OP_JALR: begin
                uses_rs1_o = 1'b1;
                ctrl_o.ex.alu_src1 = 1'b1;
                ctrl_o.ex.alu_src2 = 1'b1;
                ctrl_o.wb.reg_wr = 1'b1;
            end
            OP_BR: begin
                uses_rs1_o = 1'b1;
                uses_rs2_o = 1'b1;
                ctrl_o.ex.alu_op = ALU_SUB;
            end
            OP_STORE: begin
                uses_rs1_o = 1'b1;
                uses_rs2_o = 1'b1;
                ctrl_o.ex.alu_src2 = 1'b1;
                ctrl_o.mem.mem_wr = 1'b1;
                ctrl_o.mem.rw_type = funct3_i;
            end
            OP_LUI: begin
                ctrl_o.ex.alu_src2 = 1'b1;
                ctrl_o.ex.alu_op = ALU_PASSB;
                ctrl_o.wb.reg_wr = 1'b1;
            end
            OP_AUIPC: begin
                ctrl_o.ex.alu_src1 = 1'b1;
                ctrl_o.ex.alu_src2 = 1'b1;
                ctrl_o.wb.reg_wr = 1'b1;
            end
            OP_JAL: begin
                ctrl_o.ex.alu_src1 = 1'b1;
                ctrl_o.wb.reg_wr = 1'b1;
            end
            default: begin
                ctrl_o.valid = 1'b0;
                illegal_o = 1'b1;
            end
        endcase
        if (rd_i == '0) begin
            ctrl_o.wb.reg_wr = 1'b0;
        end
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Pipelined control unit: ID decode, EX/MEM/WB control registers, load-use and
// memory-wait stalls, branch/jump squash and EX operand-forwarding selects.
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned ALU_OP_W    = 4,
    parameter bit          MEM_WAIT_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                ex_redirect,
    input  logic                mem_ready,
    output logic                flush_if_id,
    output logic                illegal,
    output logic                ex_valid,
    output logic                ex_alu_src1,
    output logic                ex_alu_src2,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [1:0]          ex_fwd_a,
    output logic [1:0]          ex_fwd_b,
    output logic                mem_valid,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [2:0]          mem_rw_type,
    output logic                wb_valid,
    output logic                wb_reg_wr,
    output logic                wb_mem_to_reg,
    output logic [REG_AW-1:0]   wb_rd
);

    ctrl_t dec_ctrl;
    logic  dec_uses_rs1, dec_uses_rs2, dec_illegal;

    ctrl_decode #(.REG_AW(REG_AW)) u_decode (
        .opcode_i   (opcode),
        .funct3_i   (funct3),
        .funct7_5_i (funct7[5]),
        .rd_i       (id_rd),
        .ctrl_o     (dec_ctrl),
        .uses_rs1_o (dec_uses_rs1),
        .uses_rs2_o (dec_uses_rs2),
        .illegal_o  (dec_illegal)
    );

    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    ctrl_t             ex_q, ex_d;
    logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
    logic              mem_v_q, mem_v_d;
    mem_ctrl_t         mem_ctrl_q, mem_ctrl_d;
    wb_ctrl_t          mem_wb_q, mem_wb_d;
    logic [REG_AW-1:0] mem_dst_q, mem_dst_d;
    logic              wb_v_q, wb_v_d;
    wb_ctrl_t          wb_ctrl_q, wb_ctrl_d;
    logic [REG_AW-1:0] wb_dst_q, wb_dst_d;
    logic              illegal_q, illegal_d;

    logic mem_stall, load_use, accept;

    assign mem_stall = MEM_WAIT_EN && mem_v_q && (mem_ctrl_q.mem_rd || mem_ctrl_q.mem_wr) && !mem_ready;
    assign load_use  = ex_q.valid && ex_q.mem.mem_rd && (ex_rd_q != '0) &&
                       ((dec_uses_rs1 && (id_rs1 == ex_rd_q)) || (dec_uses_rs2 && (id_rs2 == ex_rd_q)));
    // A redirect consumes the ID slot even when it would otherwise load-use stall
    assign id_ready    = !mem_stall && (ex_redirect || !load_use);
    assign flush_if_id = !mem_stall && ex_redirect;
    assign accept      = id_valid && id_ready;

    always_comb begin
        ex_d       = ex_q;
        ex_rs1_d   = ex_rs1_q;
        ex_rs2_d   = ex_rs2_q;
        ex_rd_d    = ex_rd_q;
        mem_v_d    = mem_v_q;
        mem_ctrl_d = mem_ctrl_q;
        mem_wb_d   = mem_wb_q;
        mem_dst_d  = mem_dst_q;
        wb_v_d     = 1'b0;
        wb_ctrl_d  = '0;
        wb_dst_d   = '0;
        illegal_d  = accept && dec_illegal && !ex_redirect;
        if (!mem_stall) begin
            wb_v_d     = mem_v_q;
            wb_ctrl_d  = mem_wb_q;
            wb_dst_d   = mem_dst_q;
            mem_v_d    = ex_q.valid;
            mem_ctrl_d = ex_q.mem;
            mem_wb_d   = ex_q.wb;
            mem_dst_d  = ex_rd_q;
            if (accept && !ex_redirect && !dec_illegal) begin
                ex_d     = dec_ctrl;
                ex_rs1_d = id_rs1;
                ex_rs2_d = id_rs2;
                ex_rd_d  = id_rd;
            end else begin
                ex_d     = '0;
                ex_rs1_d = '0;
                ex_rs2_d = '0;
                ex_rd_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q       <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_rd_q    <= '0;
            mem_v_q    <= 1'b0;
            mem_ctrl_q <= '0;
            mem_wb_q   <= '0;
            mem_dst_q  <= '0;
            wb_v_q     <= 1'b0;
            wb_ctrl_q  <= '0;
            wb_dst_q   <= '0;
            illegal_q  <= 1'b0;
        end else begin
            ex_q       <= ex_d;
            ex_rs1_q   <= ex_rs1_d;
            ex_rs2_q   <= ex_rs2_d;
            ex_rd_q    <= ex_rd_d;
            mem_v_q    <= mem_v_d;
            mem_ctrl_q <= mem_ctrl_d;
            mem_wb_q   <= mem_wb_d;
            mem_dst_q  <= mem_dst_d;
            wb_v_q     <= wb_v_d;
            wb_ctrl_q  <= wb_ctrl_d;
            wb_dst_q   <= wb_dst_d;
            illegal_q  <= illegal_d;
        end
    end

    // Loads cannot forward from MEM: their data only exists from WB onward
    logic mem_fwd_ok, wb_fwd_ok;
    assign mem_fwd_ok = mem_v_q && mem_wb_q.reg_wr && !mem_ctrl_q.mem_rd && (mem_dst_q != '0);
    assign wb_fwd_ok  = wb_v_q && wb_ctrl_q.reg_wr && (wb_dst_q != '0);

    always_comb begin
        ex_fwd_a = FWD_RF;
        ex_fwd_b = FWD_RF;
        if (mem_fwd_ok && (mem_dst_q == ex_rs1_q)) begin
            ex_fwd_a = FWD_MEM;
        end else if (wb_fwd_ok && (wb_dst_q == ex_rs1_q)) begin
            ex_fwd_a = FWD_WB;
        end
        if (mem_fwd_ok && (mem_dst_q == ex_rs2_q)) begin
            ex_fwd_b = FWD_MEM;
        end else if (wb_fwd_ok && (wb_dst_q == ex_rs2_q)) begin
            ex_fwd_b = FWD_WB;
        end
    end

    assign illegal       = illegal_q;
    assign ex_valid      = ex_q.valid;
    assign ex_alu_src1   = ex_q.ex.alu_src1;
    assign ex_alu_src2   = ex_q.ex.alu_src2;
    assign ex_alu_op     = ALU_OP_W'(ex_q.ex.alu_op);
    assign mem_valid     = mem_v_q;
    assign mem_rd        = mem_ctrl_q.mem_rd;
    assign mem_wr        = mem_ctrl_q.mem_wr;
    assign mem_rw_type   = mem_ctrl_q.rw_type;
    assign wb_valid      = wb_v_q;
    assign wb_reg_wr     = wb_ctrl_q.reg_wr;
    assign wb_mem_to_reg = wb_ctrl_q.mem_to_reg;
    assign wb_rd         = wb_dst_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Randomised + directed bench for ctrl_pipeline: instruction-level reference
// model, WB retirement scoreboard checked by an independent monitor.
module tb_ctrl_pipeline;

    localparam int REG_AW   = 5;
    localparam int ALU_OP_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid, id_ready, ex_redirect, mem_ready, flush_if_id, illegal;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd, wb_rd;
    logic ex_valid, ex_alu_src1, ex_alu_src2;
    logic [ALU_OP_W-1:0] ex_alu_op;
    logic [1:0] ex_fwd_a, ex_fwd_b;
    logic mem_valid, mem_rd, mem_wr;
    logic [2:0] mem_rw_type;
    logic wb_valid, wb_reg_wr, wb_mem_to_reg;

    ctrl_pipeline #(.REG_AW(REG_AW), .ALU_OP_W(ALU_OP_W), .MEM_WAIT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_redirect(ex_redirect), .mem_ready(mem_ready), .flush_if_id(flush_if_id),
        .illegal(illegal), .ex_valid(ex_valid), .ex_alu_src1(ex_alu_src1),
        .ex_alu_src2(ex_alu_src2), .ex_alu_op(ex_alu_op), .ex_fwd_a(ex_fwd_a),
        .ex_fwd_b(ex_fwd_b), .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rw_type(mem_rw_type), .wb_valid(wb_valid), .wb_reg_wr(wb_reg_wr),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd)
    );

    always #5 clk = ~clk;

    typedef enum {K_BAD, K_R, K_I, K_LD, K_JALR, K_BR, K_ST, K_LUI, K_AUIPC, K_JAL} kind_e;

    typedef struct {
        bit v;
        bit legal;
        bit u1, u2;
        bit ld, st, wr, src1, src2;
        int op, rw, rd, rs1, rs2;
    } slot_t;

    typedef struct {
        bit wr;
        bit m2r;
        int rd;
    } ret_t;

    slot_t m_ex, m_mem, m_wb, nil;
    bit    m_ill;
    ret_t  wb_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic kind_e kind_of(logic [6:0] op);
        case (op)
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LD;
            7'b1100111: return K_JALR;
            7'b1100011: return K_BR;
            7'b0100011: return K_ST;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            7'b1101111: return K_JAL;
            default:    return K_BAD;
        endcase
    endfunction

    function automatic slot_t ref_decode(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                         int rd, int rs1, int rs2);
        int    base_op[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        kind_e k = kind_of(op);
        slot_t s = nil;
        s.legal = (k != K_BAD);
        s.v    = s.legal;
        s.rd   = rd;
        s.rs1  = rs1;
        s.rs2  = rs2;
        s.ld   = (k == K_LD);
        s.st   = (k == K_ST);
        s.src1 = k inside {K_AUIPC, K_JAL, K_JALR};
        s.src2 = k inside {K_I, K_LD, K_JALR, K_ST, K_LUI, K_AUIPC};
        s.wr   = (k inside {K_R, K_I, K_LD, K_JALR, K_LUI, K_AUIPC, K_JAL}) && rd != 0;
        s.u1   = k inside {K_R, K_I, K_LD, K_JALR, K_BR, K_ST};
        s.u2   = k inside {K_R, K_BR, K_ST};
        s.rw   = (s.ld || s.st) ? int'(f3) : 0;
        s.op   = 0;
        if (k == K_R || k == K_I) begin
            s.op = base_op[f3];
            if (f7[5] && f3 == 3'd5) s.op = 7;
            if (f7[5] && f3 == 3'd0 && k == K_R) s.op = 1;
        end
        if (k == K_LUI) s.op = 10;
        if (k == K_BR)  s.op = 1;
        return s;
    endfunction

    function automatic int ref_fwd(int rs);
        if (rs != 0 && m_mem.v && m_mem.wr && !m_mem.ld && m_mem.rd == rs) return 1;
        if (rs != 0 && m_wb.v && m_wb.wr && m_wb.rd == rs) return 2;
        return 0;
    endfunction

    // One clock: drive at the falling edge, check before the rising edge, advance the model.
    task automatic cycle(input bit iv, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input int rd, input int rs1, input int rs2,
                         input bit redir, input bit mrdy, output bit acc);
        slot_t d;
        bit    stall, lu, exp_ready;
        id_valid = iv; opcode = op; funct3 = f3; funct7 = f7;
        id_rd = REG_AW'(rd); id_rs1 = REG_AW'(rs1); id_rs2 = REG_AW'(rs2);
        ex_redirect = redir; mem_ready = mrdy;
        #1;
        d = ref_decode(op, f3, f7, rd, rs1, rs2);
        stall = m_mem.v && (m_mem.ld || m_mem.st) && !mrdy;
        lu = m_ex.v && m_ex.ld && m_ex.rd != 0 &&
             ((d.u1 && rs1 == m_ex.rd) || (d.u2 && rs2 == m_ex.rd));
        exp_ready = !stall && (redir || !lu);
        chk("id_ready", id_ready, exp_ready);
        chk("flush_if_id", flush_if_id, !stall && redir);
        chk("ex_valid", ex_valid, m_ex.v);
        chk("mem_valid", mem_valid, m_mem.v);
        chk("wb_valid", wb_valid, m_wb.v);
        chk("illegal", illegal, m_ill);
        if (m_ex.v) begin
            chk("ex_alu_op", ex_alu_op, m_ex.op);
            chk("ex_alu_src1", ex_alu_src1, m_ex.src1);
            chk("ex_alu_src2", ex_alu_src2, m_ex.src2);
            chk("ex_fwd_a", ex_fwd_a, ref_fwd(m_ex.rs1));
            chk("ex_fwd_b", ex_fwd_b, ref_fwd(m_ex.rs2));
        end
        if (m_mem.v) begin
            chk("mem_rd", mem_rd, m_mem.ld);
            chk("mem_wr", mem_wr, m_mem.st);
            chk("mem_rw_type", mem_rw_type, m_mem.rw);
        end else begin
            chk("mem_bubble_en", {mem_rd, mem_wr}, 0);
        end
        acc = iv && exp_ready;
        m_ill = acc && !d.legal && !redir;
        if (stall) begin
            m_wb = nil;
        end else begin
            m_wb  = m_mem;
            m_mem = m_ex;
            if (acc && d.legal && !redir) begin
                m_ex = d;
                wb_q.push_back('{wr: d.wr, m2r: d.ld, rd: rd});
            end else begin
                m_ex = nil;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit mrdy);
        bit a;
        cycle(1'b0, 7'd0, 3'd0, 7'd0, 0, 0, 0, 1'b0, mrdy, a);
    endtask

    // Retirement monitor: every WB-valid slot must match the oldest accepted instruction.
    initial begin
        ret_t r;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && wb_valid) begin
                if (wb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL wb_retire: unexpected retirement rd=%0d, expected none", wb_rd);
                end else begin
                    r = wb_q.pop_front();
                    chk("wb_reg_wr", wb_reg_wr, r.wr);
                    chk("wb_mem_to_reg", wb_mem_to_reg, r.m2r);
                    chk("wb_rd", wb_rd, r.rd);
                end
            end
        end
    end

    initial begin
        bit            acc;
        int            tries;
        logic [6:0]    ops[10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1100011,
                                   7'b0100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1111111};
        logic [6:0]    r_op, r_f7;
        logic [2:0]    r_f3;
        int            r_rd, r_rs1, r_rs2;
        bit            r_iv, fresh;

        rst_n = 1'b0;
        id_valid = 0; opcode = 0; funct3 = 0; funct7 = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; ex_redirect = 0; mem_ready = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", {ex_valid, mem_valid, wb_valid, illegal, wb_reg_wr, mem_rd, mem_wr}, 0);
        chk("rst_id_ready", id_ready, 1);
        chk("rst_flush", flush_if_id, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ex = nil; m_mem = nil; m_wb = nil; m_ill = 0;

        // ADD x3,x1,x2 ; SUB x4,x3,x1 back to back (MEM forward)
        cycle(1, 7'b0110011, 3'd0, 7'h00, 3, 1, 2, 0, 1, acc);
        cycle(1, 7'b0110011, 3'd0, 7'h20, 4, 3, 1, 0, 1, acc);
        chk("sub_no_stall", acc, 1);
        idle(1);
        // LW x5 ; ADD x6,x5,x0 (load-use bubble, then WB forward)
        cycle(1, 7'b0000011, 3'd2, 7'h00, 5, 1, 0, 0, 1, acc);
        tries = 0;
        do begin
            cycle(1, 7'b0110011, 3'd0, 7'h00, 6, 5, 0, 0, 1, acc);
            tries++;
        end while (!acc && tries < 4);
        chk("load_use_stall_cycles", tries, 2);
        repeat (3) idle(1);
        // SW with three cycles of memory wait
        cycle(1, 7'b0100011, 3'd2, 7'h00, 0, 1, 2, 0, 1, acc);
        idle(1);
        repeat (3) cycle(1, 7'b0110011, 3'd7, 7'h00, 7, 1, 2, 0, 0, acc);
        idle(1);
        repeat (3) idle(1);
        // Redirect squashing the ID instruction, then redirect under a memory stall
        cycle(1, 7'b0010011, 3'd0, 7'h00, 8, 1, 0, 0, 1, acc);
        cycle(1, 7'b0110011, 3'd0, 7'h00, 9, 1, 2, 1, 1, acc);
        idle(1);
        cycle(1, 7'b0000011, 3'd0, 7'h00, 10, 1, 0, 0, 1, acc);
        idle(1);
        cycle(1, 7'b0110011, 3'd0, 7'h00, 11, 1, 2, 1, 0, acc);
        idle(1);
        // Illegal opcode
        cycle(1, 7'b1111111, 3'd0, 7'h00, 12, 1, 2, 0, 1, acc);
        repeat (4) idle(1);

        // Randomised traffic; ID holds its instruction until accepted
        fresh = 1;
        r_iv = 0; r_op = 0; r_f3 = 0; r_f7 = 0; r_rd = 0; r_rs1 = 0; r_rs2 = 0;
        for (int i = 0; i < 3000; i++) begin
            if (fresh) begin
                r_iv = ($urandom_range(0, 9) < 8);
                r_op = ops[$urandom_range(0, 9)];
                if ($urandom_range(0, 19) == 0) r_op = 7'($urandom);
                r_f3 = 3'($urandom);
                r_f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
                r_rd = $urandom_range(0, 7);
                r_rs1 = $urandom_range(0, 7);
                r_rs2 = $urandom_range(0, 7);
            end
            cycle(r_iv, r_op, r_f3, r_f7, r_rd, r_rs1, r_rs2,
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7), acc);
            fresh = acc || !r_iv;
        end
        repeat (6) idle(1);
        chk("scoreboard_drained", wb_q.size(), 0);

        // Asynchronous reset in the middle of a memory stall
        cycle(1, 7'b0000011, 3'd1, 7'h00, 13, 2, 0, 0, 1, acc);
        idle(1);
        mem_ready = 1'b0;
        #2;
        chk("stall_before_reset", id_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {ex_valid, mem_valid, wb_valid, illegal, mem_rd, mem_wr,
                                  wb_reg_wr, wb_mem_to_reg, flush_if_id}, 0);
        wb_q.delete();
        m_ex = nil; m_mem = nil; m_wb = nil; m_ill = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_id_ready", id_ready, 1);
        @(negedge clk);
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
